ctrl_refresh_sched: RTL

//  Per-rank DDR4 refresh scheduler.
//  - One tREFI interval timer per rank, staggered so ranks do not refresh together.
//  - Keeps a count of owed refreshes per rank and raises req/urgent to the command scheduler.
//  - Times the tRFC blocking window after each REF is issued.
//  - Sits between the controller timing block and the command scheduler; the scheduler issues REF and acks.

---
 rtl/ctrl_refresh_sched_if.sv | 28 ++
 rtl/ctrl_refresh_sched.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ctrl_refresh_sched_if.sv
// rtl/ctrl_refresh_sched_if.sv - refresh scheduler bus between timing/command scheduler and the refresh block
interface ctrl_refresh_sched_if #(
    parameter int NUM_RANKS = 2,
    parameter int PW        = 4
);
    logic                      refresh_en;
    logic                      clear_refresh;
    logic [NUM_RANKS-1:0]      ref_ack;
    logic [NUM_RANKS-1:0]      ref_req;
    logic [NUM_RANKS-1:0]      ref_urgent;
    logic [NUM_RANKS-1:0]      refresh_almost;
    logic [NUM_RANKS-1:0]      in_refresh;
    logic [NUM_RANKS-1:0]      refresh_done;
    logic [NUM_RANKS*PW-1:0]   pending_cnt;
    logic [NUM_RANKS-1:0]      ref_overflow;

    modport master (
        output refresh_en, clear_refresh, ref_ack,
        input  ref_req, ref_urgent, refresh_almost, in_refresh,
               refresh_done, pending_cnt, ref_overflow
    );

    modport slave (
        input  refresh_en, clear_refresh, ref_ack,
        output ref_req, ref_urgent, refresh_almost, in_refresh,
               refresh_done, pending_cnt, ref_overflow
    );
endinterface

// File: rtl/ctrl_refresh_sched.sv
// rtl/ctrl_refresh_sched.sv - per-rank DDR4 refresh scheduler; REFRESH_POSTPONE_EN allows up to MAX_POSTPONE owed refreshes
module ctrl_refresh_sched #(
    parameter int NUM_RANKS    = 2,
    parameter int TREFI        = 7800,
    parameter int TRFC         = 350,
    parameter int ALMOST_LEAD  = 10,
    parameter int MAX_POSTPONE = 8,
    parameter int CNT_W        = 16
) (
    input  logic                 CK_t,
    input  logic                 RESET_n,
    ctrl_refresh_sched_if.slave  bus
);
    localparam int PW = $clog2(MAX_POSTPONE + 1);
`ifdef REFRESH_POSTPONE_EN
    localparam int LIMIT = MAX_POSTPONE;
`else
    localparam int LIMIT = 1;
`endif
    localparam logic [CNT_W-1:0] IVL_LAST   = CNT_W'(TREFI - 1);
    localparam logic [CNT_W-1:0] ALMOST_TH  = CNT_W'(TREFI - ALMOST_LEAD);
    localparam logic [CNT_W-1:0] RFC_LOAD   = CNT_W'(TRFC - 1);
    localparam logic [PW-1:0]    PEND_LIMIT = PW'(LIMIT);

    typedef enum logic {
        ST_IDLE,
        ST_RFC
    } state_t;

    logic [NUM_RANKS-1:0]    w_req_v;
    logic [NUM_RANKS-1:0]    w_urgent_v;
    logic [NUM_RANKS-1:0]    w_almost_v;
    logic [NUM_RANKS-1:0]    w_inref_v;
    logic [NUM_RANKS-1:0]    w_done_v;
    logic [NUM_RANKS-1:0]    w_ovf_v;
    logic [NUM_RANKS*PW-1:0] w_pend_v;

    for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
        // Staggered start phase keeps ranks from refreshing in the same cycle
        localparam logic [CNT_W-1:0] STAGGER = CNT_W'(r * (TREFI / NUM_RANKS));

        state_t           r_state;
        state_t           w_state_nxt;
        logic [CNT_W-1:0] r_ivl;
        logic [CNT_W-1:0] w_ivl_nxt;
        logic [CNT_W-1:0] r_rfc;
        logic [CNT_W-1:0] w_rfc_nxt;
        logic [PW-1:0]    r_pend;
        logic [PW-1:0]    w_pend_nxt;
        logic             r_ovf;
        logic             w_ovf_nxt;
        logic             r_almost;
        logic             r_done;
        logic             w_done_nxt;
        logic             w_tick;
        logic             w_req;
        logic             w_acc;

        assign w_tick = bus.refresh_en && (r_ivl == IVL_LAST);
        assign w_req  = (r_state == ST_IDLE) && (r_pend != '0);
        assign w_acc  = bus.ref_ack[r] && w_req && !bus.clear_refresh;

        assign w_ivl_nxt = bus.clear_refresh      ? STAGGER :
                           !bus.refresh_en        ? r_ivl :
                           (r_ivl == IVL_LAST)    ? '0 :
                                                    r_ivl + 1'b1;

        always_comb begin
            w_pend_nxt = r_pend;
            w_ovf_nxt  = r_ovf;
            if (bus.clear_refresh) begin
                w_pend_nxt = '0;
                w_ovf_nxt  = 1'b0;
            end else begin
                // An ack the rank could not take is a protocol error
                if (bus.ref_ack[r] && !w_req) begin
                    w_ovf_nxt = 1'b1;
                end
                if (w_tick && !w_acc) begin
                    if (r_pend == PEND_LIMIT) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_pend_nxt = r_pend + 1'b1;
                    end
                end else if (w_acc && !w_tick) begin
                    w_pend_nxt = r_pend - 1'b1;
                end
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_rfc_nxt   = r_rfc;
            w_done_nxt  = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        w_state_nxt = ST_RFC;
                        w_rfc_nxt   = RFC_LOAD;
                    end
                end
                ST_RFC: begin
                    if (r_rfc == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_rfc_nxt = r_rfc - 1'b1;
                    end
                end
            endcase
        end

        // tRFC window deliberately ignores clear_refresh so it is never shortened
        always_ff @(posedge CK_t or negedge RESET_n) begin
            if (!RESET_n) begin
                r_state <= ST_IDLE;
                r_rfc   <= '0;
                r_done  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_rfc   <= w_rfc_nxt;
                r_done  <= w_done_nxt;
            end
        end

        always_ff @(posedge CK_t or negedge RESET_n) begin
            if (!RESET_n) begin
                r_ivl    <= STAGGER;
                r_pend   <= '0;
                r_ovf    <= 1'b0;
                r_almost <= 1'b0;
            end else begin
                r_ivl    <= w_ivl_nxt;
                r_pend   <= w_pend_nxt;
                r_ovf    <= w_ovf_nxt;
                r_almost <= !bus.clear_refresh && bus.refresh_en && (w_ivl_nxt >= ALMOST_TH);
            end
        end

        assign w_req_v[r]            = w_req;
`ifdef REFRESH_POSTPONE_EN
        assign w_urgent_v[r]         = w_req && (r_pend >= PEND_LIMIT);
`else
        assign w_urgent_v[r]         = w_req;
`endif
        assign w_almost_v[r]         = r_almost;
        assign w_inref_v[r]          = (r_state == ST_RFC);
        assign w_done_v[r]           = r_done;
        assign w_ovf_v[r]            = r_ovf;
        assign w_pend_v[r*PW +: PW]  = r_pend;
    end

    assign bus.ref_req        = w_req_v;
    assign bus.ref_urgent     = w_urgent_v;
    assign bus.refresh_almost = w_almost_v;
    assign bus.in_refresh     = w_inref_v;
    assign bus.refresh_done   = w_done_v;
    assign bus.ref_overflow   = w_ovf_v;
    assign bus.pending_cnt    = w_pend_v;
endmodule
